// File: rtl/max7219_frame_scheduler.sv
// MAX7219 frame scheduler: power-up init list, then dirty-register updates
// over a 16-bit mode-0 SPI link, with optional periodic full-digit refresh.
module max7219_frame_scheduler #(
  parameter int CLK_DIV        = 2,
  parameter int POR_CYCLES     = 50000,
  parameter int CS_GAP         = 4,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [63:0] digits_i,
  input  logic [3:0]  intensity_i,
  input  logic        blank_i,
  output logic        spi_clk_o,
  output logic        spi_din_o,
  output logic        spi_cs_n_o,
  output logic        busy_o,
  output logic        init_done_o
);

  typedef enum logic [2:0] {
    POR_WAIT, INIT, IDLE, LOAD, SHIFT, GAP
  } state_e;

  localparam logic [31:0] POR_LAST = 32'(POR_CYCLES - 1);
  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0] GAP_LAST = 32'(CS_GAP - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  half_q, half_d;
  logic        sclk_q, sclk_d;
  logic [15:0] sh_q, sh_d;
  logic        cs_n_q, cs_n_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  force_q, force_d;
  logic [63:0] dsh_q, dsh_d;
  logic [3:0]  int_sh_q, int_sh_d;
  logic        blank_sh_q, blank_sh_d;
  logic        init_done_q, init_done_d;

  logic        ref_wrap;
  logic [7:0]  dirty;
  logic        found;
  logic [2:0]  sel;
  logic [2:0]  idx;
  logic [3:0]  addr;
  logic [15:0] init_word;

  if (REFRESH_CYCLES != 0) begin : g_ref
    localparam logic [31:0] REF_LAST = 32'(REFRESH_CYCLES - 1);
    logic [31:0] ref_q;
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        ref_q <= '0;
      end else if (ref_q == REF_LAST) begin
        ref_q <= '0;
      end else begin
        ref_q <= ref_q + 32'd1;
      end
    end
    assign ref_wrap = (ref_q == REF_LAST);
  end else begin : g_noref
    assign ref_wrap = 1'b0;
  end

  always_comb begin
    dirty = '0;
    for (int i = 0; i < 8; i++) begin
      dirty[i] = force_q[i] |
                 (digits_i[8*i +: 8] != dsh_q[8*i +: 8]);
    end
  end

  // Round-robin digit search starting at ptr
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && dirty[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    addr = {1'b0, sel} + 4'd1;
  end

  always_comb begin
    unique case (init_idx_q)
      3'd0:    init_word = 16'h0C00;
      3'd1:    init_word = 16'h0900;
      3'd2:    init_word = 16'h0B07;
      3'd3:    init_word = {12'h0A0, intensity_i};
      3'd4:    init_word = 16'h0F00;
      default: init_word = {12'h0C0, 3'b000, ~blank_i};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    sclk_d      = sclk_q;
    sh_d        = sh_q;
    cs_n_d      = cs_n_q;
    init_idx_d  = init_idx_q;
    ptr_d       = ptr_q;
    force_d     = force_q;
    dsh_d       = dsh_q;
    int_sh_d    = int_sh_q;
    blank_sh_d  = blank_sh_q;
    init_done_d = init_done_q;
    unique case (state_q)
      POR_WAIT: begin
        if (cnt_q == POR_LAST) begin
          cnt_d   = '0;
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      INIT: begin
        sh_d       = init_word;
        init_idx_d = init_idx_q + 3'd1;
        if (init_idx_q == 3'd3) int_sh_d = intensity_i;
        if (init_idx_q == 3'd5) blank_sh_d = blank_i;
        state_d = LOAD;
        cs_n_d  = 1'b0;
        cnt_d   = '0;
        half_d  = '0;
      end
      IDLE: begin
        if (force_q == 8'h00) init_done_d = 1'b1;
        if (blank_i != blank_sh_q) begin
          sh_d       = {12'h0C0, 3'b000, ~blank_i};
          blank_sh_d = blank_i;
          state_d    = LOAD;
        end else if (intensity_i != int_sh_q) begin
          sh_d     = {12'h0A0, intensity_i};
          int_sh_d = intensity_i;
          state_d  = LOAD;
        end else if (found) begin
          sh_d = {4'h0, addr, digits_i[{sel, 3'b000} +: 8]};
          dsh_d[{sel, 3'b000} +: 8] = digits_i[{sel, 3'b000} +: 8];
          force_d[sel] = 1'b0;
          ptr_d   = sel + 3'd1;
          state_d = LOAD;
        end
        if (state_d == LOAD) begin
          cs_n_d = 1'b0;
          cnt_d  = '0;
          half_d = '0;
        end
      end
      LOAD, SHIFT: begin
        state_d = SHIFT;
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 5'd1;
          // Data advances only on the falling SPI clock edge
          if (sclk_q) sh_d = {sh_q[14:0], 1'b0};
          if (half_q == 5'd31) begin
            state_d = GAP;
            cs_n_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (init_idx_q < 3'd6) ? INIT : IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = POR_WAIT;
    endcase
    if (ref_wrap) force_d = 8'hFF;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= POR_WAIT;
      cnt_q       <= '0;
      half_q      <= '0;
      sclk_q      <= 1'b0;
      sh_q        <= '0;
      cs_n_q      <= 1'b1;
      init_idx_q  <= '0;
      ptr_q       <= '0;
      force_q     <= 8'hFF;
      dsh_q       <= '0;
      int_sh_q    <= '0;
      blank_sh_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      sclk_q      <= sclk_d;
      sh_q        <= sh_d;
      cs_n_q      <= cs_n_d;
      init_idx_q  <= init_idx_d;
      ptr_q       <= ptr_d;
      force_q     <= force_d;
      dsh_q       <= dsh_d;
      int_sh_q    <= int_sh_d;
      blank_sh_q  <= blank_sh_d;
      init_done_q <= init_done_d;
    end
  end

  assign spi_clk_o   = sclk_q;
  assign spi_din_o   = sh_q[15];
  assign spi_cs_n_o  = cs_n_q;
  assign busy_o      = (state_q != IDLE);
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Scoreboard bench: two schedulers (no refresh / 2000-cycle refresh),
// SPI frames decoded by per-DUT monitors and matched to expected queues.
module tb_max7219_frame_scheduler;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [63:0] digits0, digits1;
  logic [3:0]  inten0, inten1;
  logic        blank0, blank1;
  logic [1:0]  cs_n, sclk, din, busy, idone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] expq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  max7219_frame_scheduler #(
    .CLK_DIV(2), .POR_CYCLES(10), .CS_GAP(4), .REFRESH_CYCLES(0)
  ) dut0 (
    .clock_i(clk), .reset_i(rst[0]), .digits_i(digits0),
    .intensity_i(inten0), .blank_i(blank0),
    .spi_clk_o(sclk[0]), .spi_din_o(din[0]), .spi_cs_n_o(cs_n[0]),
    .busy_o(busy[0]), .init_done_o(idone[0])
  );

  max7219_frame_scheduler #(
    .CLK_DIV(2), .POR_CYCLES(10), .CS_GAP(4), .REFRESH_CYCLES(2000)
  ) dut1 (
    .clock_i(clk), .reset_i(rst[1]), .digits_i(digits1),
    .intensity_i(inten1), .blank_i(blank1),
    .spi_clk_o(sclk[1]), .spi_din_o(din[1]), .spi_cs_n_o(cs_n[1]),
    .busy_o(busy[1]), .init_done_o(idone[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_mon
    bit          act = 1'b0;
    int          nb, len;
    logic [15:0] w, e;
    logic        pv = 1'b0;
    always @(negedge clk) begin
      if (rst[g]) begin
        act = 1'b0;
      end else if (!cs_n[g]) begin
        if (!act) begin
          act = 1'b1; nb = 0; len = 0; w = '0;
        end
        len++;
        if (sclk[g] && !pv) begin
          w = {w[14:0], din[g]};
          nb++;
        end
      end else if (act) begin
        act = 1'b0;
        checks++;
        if (expq[g].size() == 0) begin
          errors++;
          $display("FAIL frame dut%0d unexpected got %h", g, w);
        end else begin
          e = expq[g].pop_front();
          if (w !== e || nb != 16) begin
            errors++;
            $display("FAIL frame dut%0d got %h (%0d bits) want %h",
                     g, w, nb, e);
          end
        end
        checks++;
        if (len != 64) begin
          errors++;
          $display("FAIL cs_low dut%0d got %0d want 64", g, len);
        end
      end
      pv = sclk[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [15:0] dword(input int i,
                                        input logic [63:0] d);
    return {4'h0, 4'(i + 1), d[8*i +: 8]};
  endfunction

  task automatic push_init(input int g, input logic [3:0] inten,
                           input logic blank, input logic [63:0] d);
    expq[g].push_back(16'h0C00);
    expq[g].push_back(16'h0900);
    expq[g].push_back(16'h0B07);
    expq[g].push_back({12'h0A0, inten});
    expq[g].push_back(16'h0F00);
    expq[g].push_back({12'h0C0, 3'b000, ~blank});
    for (int i = 0; i < 8; i++) expq[g].push_back(dword(i, d));
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 6 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!busy[0]) q++;
      else q = 0;
    end
    chk({name, "_quiet"}, 32'(q >= 6), 32'd1);
    chk({name, "_drained"}, 32'(expq[0].size()), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!idone[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_init_done"}, 32'(idone[0]), 32'd1);
    wait_quiet(name);
    chk({name, "_busy"}, 32'(busy[0]), 32'd0);
  endtask

  initial begin
    int r;
    int n;
    logic pv;
    rst     = 2'b11;
    digits0 = 64'h0807060504030201;
    inten0  = 4'h3;
    blank0  = 1'b0;
    digits1 = 64'h8877665544332211;
    inten1  = 4'h5;
    blank1  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rst_sclk", 32'(sclk[0]), 32'd0);
    chk("rst_din", 32'(din[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_idone", 32'(idone[0]), 32'd0);
    push_init(0, inten0, blank0, digits0);
    push_init(1, inten1, blank1, digits1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) expq[1].push_back(dword(i, digits1));
    end
    rst = 2'b00;
    repeat (5) @(negedge clk);
    chk("por_cs_n", 32'(cs_n[0]), 32'd1);
    wait_done("t1");

    digits0[31:24] = 8'h5B;
    expq[0].push_back(16'h045B);
    wait_quiet("t2");

    digits0[15:8]  = 8'hAA;
    digits0[55:48] = 8'h66;
    expq[0].push_back(16'h0766);
    expq[0].push_back(16'h02AA);
    wait_quiet("t3");

    blank0        = 1'b1;
    digits0[7:0]  = 8'h3C;
    expq[0].push_back(16'h0C00);
    expq[0].push_back(16'h013C);
    wait_quiet("t4a");
    blank0 = 1'b0;
    expq[0].push_back(16'h0C01);
    wait_quiet("t4b");
    inten0         = 4'h9;
    digits0[39:32] = 8'h05;
    digits0[47:40] = 8'h55;
    expq[0].push_back(16'h0A09);
    expq[0].push_back(16'h0655);
    wait_quiet("t4c");

    digits0[47:40] = 8'h77;
    r  = 0;
    n  = 0;
    pv = 1'b0;
    while (r < 10 && n < 400) begin
      @(negedge clk);
      n++;
      if (sclk[0] && !pv) r++;
      pv = sclk[0];
    end
    chk("t5_sclk_rises", 32'(r), 32'd10);
    #2 rst[0] = 1'b1;
    #1;
    chk("t5_cs_n", 32'(cs_n[0]), 32'd1);
    chk("t5_sclk", 32'(sclk[0]), 32'd0);
    chk("t5_busy", 32'(busy[0]), 32'd1);
    chk("t5_idone", 32'(idone[0]), 32'd0);
    repeat (3) @(negedge clk);
    push_init(0, inten0, blank0, digits0);
    rst[0] = 1'b0;
    wait_done("t5");

    while (cyc < 5300) @(negedge clk);
    chk("t6_drained", 32'(expq[1].size()), 32'd0);
    chk("t6_idone", 32'(idone[1]), 32'd1);
    chk("t6_busy", 32'(busy[1]), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
